matrix_scan_driver: RTL and testbench



---
 rtl/matrix_pkg.sv | 24 ++
 rtl/matrix_frame_buffer.sv | 55 +++++
 rtl/matrix_scan_driver.sv | 209 ++++++++++++++++++++
 tb/tb_matrix_scan_driver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types, constants and size helpers for the LED matrix column-scan driver.
package matrix_pkg;

  // Scan phase of the column driver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Row level driven while a column is blanked; replicate to ROWS bits.
  localparam logic BLANK_LEVEL = 1'b0;

  // Total number of columns across the whole panel chain.
  function automatic int calc_total(input int panels, input int cols_per_panel);
    return panels * cols_per_panel;
  endfunction

  // Column address width; at least one bit so single-column builds stay legal.
  function automatic int calc_aw(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/matrix_frame_buffer.sv
// Two-bank frame store: host side writes the back bank, scan side reads the front bank.
// Bank select toggles on i_swap; reads use the post-swap bank so a swap and the
// first column of the new frame line up on the same clock edge.
module matrix_frame_buffer #(
  parameter int ROWS = 16,
  parameter int AW   = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_swap,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [ROWS-1:0] i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  output logic [ROWS-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** (AW + 1);

  logic [ROWS-1:0] r_mem [0:DEPTH-1];
  logic [ROWS-1:0] r_rd_data;
  logic            r_front;
  logic            w_front_next;
  logic [AW:0]     w_wr_full;
  logic [AW:0]     w_rd_full;

  assign w_front_next = r_front ^ i_swap;
  // Writes always land in the bank that is back *before* this edge's swap.
  assign w_wr_full    = {~r_front, i_wr_addr};
  assign w_rd_full    = {w_front_next, i_rd_addr};
  assign o_rd_data    = r_rd_data;

  // Front bank select register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_front <= 1'b0;
    end else begin
      r_front <= w_front_next;
    end
  end

  // Block RAM with registered read; a write into the bank being swapped in is
  // forwarded so it is displayed immediately.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[w_wr_full] <= i_wr_data;
    end
    if (i_we && (w_wr_full == w_rd_full)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[w_rd_full];
    end
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Column-scan driver for chained LED dot-matrix panels with double buffering,
// frame-synchronous bank swap, horizontal scroll and a back-bank clear engine.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROWS           = 16,
  parameter int COLS_PER_PANEL = 8,
  parameter int PANELS         = 4,
  parameter int DIV            = 1024,
  parameter int SCROLL_DIV     = 8,
  localparam int TOTAL         = calc_total(PANELS, COLS_PER_PANEL),
  localparam int AW            = calc_aw(TOTAL)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [ROWS-1:0]   wr_data,
  input  logic              swap_req,
  input  logic              clr_req,
  input  logic              scroll_en,
  input  logic              IN_CLR,
  output logic [ROWS-1:0]   row_data,
  output logic [PANELS-1:0] panel_strobe_n,
  output logic              COLUMN_CLK,
  output logic              OUT_CLR,
  output logic              frame_end,
  output logic              swap_pending,
  output logic              clr_busy
);

  localparam int DW = $clog2(DIV);
  localparam int FW = $clog2(SCROLL_DIV + 1);
  localparam logic [AW-1:0] LAST_COL = AW'(TOTAL - 1);

  scan_state_t     r_state;
  scan_state_t     w_state_next;
  logic [DW-1:0]   r_div_cnt;
  logic            w_tick;
  logic [AW-1:0]   r_col_idx;
  logic [AW-1:0]   w_col_next;
  logic [AW-1:0]   r_offset;
  logic [AW-1:0]   w_offset_next;
  logic [FW-1:0]   r_frame_cnt;
  logic            w_enter_drive;
  logic            w_frame_edge;
  logic            w_scroll_wrap;
  logic            w_swap;
  logic            r_swap_pending;
  logic            r_clr_busy;
  logic [AW-1:0]   r_clr_addr;
  logic            r_column_clk;
  logic            r_frame_end;
  logic [AW:0]     w_sum;
  logic [AW:0]     w_sum_wrapped;
  logic [AW-1:0]   w_rd_addr;
  logic            w_wr_ok;
  logic            w_we;
  logic [AW-1:0]   w_wa;
  logic [ROWS-1:0] w_wd;
  logic [ROWS-1:0] w_rd_data;

  assign w_tick = (r_div_cnt == DW'(DIV - 1));

  // Scan phase divider: one tick every DIV clocks.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
    end
  end

  // Scan state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next scan phase plus the drive-entry and frame-boundary strobes.
  always_comb begin
    w_state_next  = r_state;
    w_enter_drive = 1'b0;
    w_frame_edge  = 1'b0;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          w_state_next  = DRIVE;
          w_enter_drive = 1'b1;
        end
        DRIVE: begin
          w_state_next = BLANK;
        end
        BLANK: begin
          w_state_next  = DRIVE;
          w_enter_drive = 1'b1;
          w_frame_edge  = (r_col_idx == LAST_COL);
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign w_col_next    = (w_tick && (r_state == BLANK))
                         ? ((r_col_idx == LAST_COL) ? '0 : r_col_idx + AW'(1))
                         : r_col_idx;
  assign w_scroll_wrap = w_frame_edge && scroll_en && (r_frame_cnt == FW'(SCROLL_DIV - 1));
  assign w_offset_next = w_scroll_wrap
                         ? ((r_offset == LAST_COL) ? '0 : r_offset + AW'(1))
                         : r_offset;
  // A pending swap waits while the clear engine still owns the back bank.
  assign w_swap        = w_frame_edge && r_swap_pending && !r_clr_busy;

  // Column index, scroll offset and scroll frame counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_col_idx   <= '0;
      r_offset    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_col_idx <= w_col_next;
      r_offset  <= w_offset_next;
      if (w_frame_edge && scroll_en) begin
        r_frame_cnt <= (r_frame_cnt == FW'(SCROLL_DIV - 1)) ? '0 : r_frame_cnt + FW'(1);
      end
    end
  end

  // Swap request latch; cleared when the swap is applied at a frame boundary.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_swap_pending <= 1'b0;
    end else if (w_swap) begin
      r_swap_pending <= swap_req;
    end else begin
      r_swap_pending <= r_swap_pending | swap_req;
    end
  end

  // Clear engine: zero one back-bank address per clock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_clr_busy <= 1'b0;
      r_clr_addr <= '0;
    end else if (r_clr_busy) begin
      if (r_clr_addr == LAST_COL) begin
        r_clr_busy <= 1'b0;
      end
      r_clr_addr <= r_clr_addr + AW'(1);
    end else if (clr_req) begin
      r_clr_busy <= 1'b1;
      r_clr_addr <= '0;
    end
  end

  // One-cycle column advance and frame-end pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_column_clk <= 1'b0;
      r_frame_end  <= 1'b0;
    end else begin
      r_column_clk <= w_enter_drive;
      r_frame_end  <= w_frame_edge;
    end
  end

  // Read address uses the post-edge column and offset so data and state align.
  assign w_sum         = {1'b0, w_col_next} + {1'b0, w_offset_next};
  assign w_sum_wrapped = (w_sum >= (AW + 1)'(TOTAL)) ? w_sum - (AW + 1)'(TOTAL) : w_sum;
  assign w_rd_addr     = w_sum_wrapped[AW-1:0];

  assign w_wr_ok = wr_en && !r_clr_busy && (32'(wr_addr) < 32'(TOTAL));
  assign w_we    = r_clr_busy | w_wr_ok;
  assign w_wa    = r_clr_busy ? r_clr_addr : wr_addr;
  assign w_wd    = r_clr_busy ? {ROWS{BLANK_LEVEL}} : wr_data;

  matrix_frame_buffer #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_frame_buffer (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_swap    (w_swap),
    .i_we      (w_we),
    .i_wr_addr (w_wa),
    .i_wr_data (w_wd),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign row_data     = (r_state == DRIVE) ? w_rd_data : {ROWS{BLANK_LEVEL}};
  assign COLUMN_CLK   = r_column_clk;
  assign frame_end    = r_frame_end;
  assign swap_pending = r_swap_pending;
  assign clr_busy     = r_clr_busy;
  assign OUT_CLR      = IN_CLR | RESET;

  // Panel-start strobe: low while driving the first column of that panel.
  for (genvar gi = 0; gi < PANELS; gi++) begin : g_strobe
    assign panel_strobe_n[gi] = !((r_state == DRIVE) &&
                                  (r_col_idx == AW'(gi * COLS_PER_PANEL)));
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver: random data against a frame-level reference model.
module tb_matrix_scan_driver;

  localparam int ROWS  = 16;
  localparam int CPP   = 4;
  localparam int PAN   = 2;
  localparam int DIV   = 2;
  localparam int SDIV  = 2;
  localparam int TOTAL = PAN * CPP;
  localparam int AW    = 3;

  logic            clk;
  logic            rst;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [ROWS-1:0] wr_data;
  logic            swap_req;
  logic            clr_req;
  logic            scroll_en;
  logic            in_clr;
  logic [ROWS-1:0] row_data;
  logic [PAN-1:0]  panel_strobe_n;
  logic            column_clk;
  logic            out_clr;
  logic            frame_end;
  logic            swap_pending;
  logic            clr_busy;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_scan_driver #(
    .ROWS           (ROWS),
    .COLS_PER_PANEL (CPP),
    .PANELS         (PAN),
    .DIV            (DIV),
    .SCROLL_DIV     (SDIV)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .swap_req       (swap_req),
    .clr_req        (clr_req),
    .scroll_en      (scroll_en),
    .IN_CLR         (in_clr),
    .row_data       (row_data),
    .panel_strobe_n (panel_strobe_n),
    .COLUMN_CLK     (column_clk),
    .OUT_CLR        (out_clr),
    .frame_end      (frame_end),
    .swap_pending   (swap_pending),
    .clr_busy       (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycle label m_n counts clock edges since reset release.
  // Scan position follows from arithmetic on m_n; banks are plain arrays.
  int              m_n;
  bit              m_front;
  int              m_off;
  int              m_fcnt;
  bit              m_pend;
  int              m_busy_end;
  bit              m_fe;
  logic [ROWS-1:0] m_bank [2][TOTAL];
  bit              m_val  [2][TOTAL];
  int              colclk_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_front = 0; m_off = 0; m_fcnt = 0; m_pend = 0; m_busy_end = 0; m_fe = 0;
    end else begin
      int  nn;
      int  ph;
      int  c;
      bit  busy_b;
      nn     = m_n + 1;
      ph     = nn / DIV;
      c      = (ph - 1) / 2;
      busy_b = (m_n < m_busy_end);
      m_fe   = (nn % DIV == 0) && (ph % 2 == 1) && (c > 0) && (c % TOTAL == 0);
      if (wr_en && !busy_b && (int'(wr_addr) < TOTAL)) begin
        m_bank[!m_front][wr_addr] = wr_data;
        m_val[!m_front][wr_addr]  = 1;
      end
      if (clr_req && !busy_b) begin
        for (int k = 0; k < TOTAL; k++) begin
          m_bank[!m_front][k] = '0;
          m_val[!m_front][k]  = 1;
        end
        m_busy_end = nn + TOTAL;
      end
      if (m_fe) begin
        if (m_pend && !busy_b) begin
          m_front = !m_front;
          m_pend  = 0;
        end
        if (scroll_en) begin
          m_fcnt++;
          if (m_fcnt == SDIV) begin
            m_fcnt = 0;
            m_off  = (m_off + 1) % TOTAL;
          end
        end
      end
      if (swap_req) m_pend = 1;
      m_n = nn;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    int             ph;
    int             col;
    int             idx;
    bit             drv;
    logic [PAN-1:0] exp_stb;
    @(negedge clk);
    ph      = m_n / DIV;
    drv     = (m_n >= DIV) && (ph % 2 == 1);
    col     = drv ? ((ph - 1) / 2) % TOTAL : 0;
    idx     = (col + m_off) % TOTAL;
    exp_stb = '1;
    if (drv && (col % CPP == 0)) exp_stb[col / CPP] = 1'b0;
    if (!drv) check_eq("row_blank", 32'(row_data), 32'd0);
    else if (m_val[m_front][idx]) check_eq("row_drive", 32'(row_data), 32'(m_bank[m_front][idx]));
    check_eq("strobe", 32'(panel_strobe_n), 32'(exp_stb));
    check_eq("column_clk", 32'(column_clk), 32'(drv && (m_n % DIV == 0)));
    check_eq("frame_end", 32'(frame_end), 32'(m_fe));
    check_eq("swap_pending", 32'(swap_pending), 32'(m_pend));
    check_eq("clr_busy", 32'(clr_busy), 32'(m_n < m_busy_end));
    check_eq("out_clr", 32'(out_clr), 32'(in_clr));
    if (frame_end) begin
      check_eq("colclk_per_frame", 32'(colclk_cnt), 32'(TOTAL));
      colclk_cnt = 0;
    end
    if (column_clk) colclk_cnt++;
  endtask

  task automatic wait_fe();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_end && k < 200);
    check_eq("frame_end_wait", 32'(frame_end), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_row"}, 32'(row_data), 32'd0);
    check_eq({tag, "_strobe"}, 32'(panel_strobe_n), 32'(2'b11));
    check_eq({tag, "_colclk"}, 32'(column_clk), 32'd0);
    check_eq({tag, "_fe"}, 32'(frame_end), 32'd0);
    check_eq({tag, "_pend"}, 32'(swap_pending), 32'd0);
    check_eq({tag, "_busy"}, 32'(clr_busy), 32'd0);
    check_eq({tag, "_outclr"}, 32'(out_clr), 32'd1);
  endtask

  initial begin
    int              bsy;
    int              k;
    logic [ROWS-1:0] zor;
    logic [ROWS-1:0] d;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    clr_req = 1'b0; scroll_en = 1'b0; in_clr = 1'b0; colclk_cnt = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Load walking-one pattern into the back bank and request a swap
    for (int i = 0; i < TOTAL; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'(1 << i);
      $display("write addr=%0d data=%04h", i, wr_data);
      step();
    end
    wr_en = 1'b0; swap_req = 1'b1;
    $display("swap request");
    step();
    swap_req = 1'b0;
    wait_fe();
    check_eq("frame2_first_col", 32'(row_data), 32'h0001);
    wait_fe();

    // Scroll: offset advances every SDIV frames and wraps after TOTAL steps
    scroll_en = 1'b1;
    $display("scroll on");
    for (int f = 1; f <= 18; f++) begin
      wait_fe();
      check_eq("scroll_first_col", 32'(row_data), 32'(1 << ((f / SDIV) % TOTAL)));
    end
    scroll_en = 1'b0;
    $display("scroll off");
    repeat (2) begin
      wait_fe();
      check_eq("scroll_frozen", 32'(row_data), 32'h0002);
    end

    // Clear straddling a frame boundary, swap requested during the clear
    repeat (26) step();
    clr_req = 1'b1;
    $display("clear request");
    step();
    clr_req = 1'b0;
    bsy = 0;
    for (int i = 0; i < 14; i++) begin
      if (clr_busy) bsy++;
      swap_req = (i == 0);
      wr_en    = (i < TOTAL) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_addr  = AW'($urandom_range(0, TOTAL - 1));
      wr_data  = 16'($urandom);
      step();
    end
    wr_en = 1'b0; swap_req = 1'b0;
    check_eq("clr_busy_len", 32'(bsy), 32'(TOTAL));
    wait_fe();
    zor = row_data;
    for (int i = 0; i < 2 * DIV * TOTAL - 1; i++) begin
      step();
      zor = zor | row_data;
    end
    check_eq("cleared_frame_or", 32'(zor), 32'd0);

    // Random back-bank fill, swap, and a write in the swap cycle
    wait_fe();
    for (int i = 0; i < TOTAL; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'($urandom);
      $display("write addr=%0d data=%04h", i, wr_data);
      step();
    end
    wr_en = 1'b0; swap_req = 1'b1;
    $display("swap request");
    step();
    swap_req = 1'b0;
    repeat (2 * DIV * TOTAL - TOTAL - 2) step();
    d = 16'($urandom);
    wr_en = 1'b1; wr_addr = AW'(m_off); wr_data = d;
    $display("write addr=%0d data=%04h in swap cycle", m_off, d);
    step();
    wr_en = 1'b0;
    check_eq("swap_cycle_fe", 32'(frame_end), 32'd1);
    check_eq("swap_cycle_write", 32'(row_data), 32'(d));
    wait_fe();

    // Asynchronous reset in the middle of a DRIVE phase
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!column_clk && k < 20);
    check_eq("pend_before_reset", 32'(swap_pending), 32'd1);
    check_eq("drive_before_reset", 32'(column_clk), 32'd1);
    #2 rst = 1'b1;
    $display("reset asserted mid-drive");
    #1 check_reset_outputs("rst_drive");
    @(negedge clk);
    rst = 1'b0;
    colclk_cnt = 0;
    repeat (40) step();

    // Asynchronous reset in the middle of a clear
    clr_req = 1'b1;
    $display("clear request");
    step();
    clr_req = 1'b0;
    step();
    check_eq("busy_before_reset", 32'(clr_busy), 32'd1);
    #2 rst = 1'b1;
    $display("reset asserted mid-clear");
    #1 check_reset_outputs("rst_clear");
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("outclr_low", 32'(out_clr), 32'd0);
    in_clr = 1'b1;
    #1 check_eq("outclr_follow_hi", 32'(out_clr), 32'd1);
    in_clr = 1'b0;
    #1 check_eq("outclr_follow_lo", 32'(out_clr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
